// File: rtl/aes_pkg.sv
// Shared AES ShiftRows helpers: NB legality, row offsets, permutation, FSM state type.
package aes_pkg;

    localparam int MaxNb = 8;

    typedef logic [31:0] col_word_t;

    typedef enum logic [1:0] {StEmpty, StOne, StFull} skid_state_e;

    function automatic bit nb_legal(input int nb);
        return (nb == 4) || (nb == 6) || (nb == 8);
    endfunction

    function automatic int row_offset(input int nb, input int r);
        int off;
        case (r)
            0:       off = 0;
            1:       off = 1;
            2:       off = (nb == 8) ? 3 : 2;
            default: off = (nb == 8) ? 4 : 3;
        endcase
        return off;
    endfunction

    // Block is right-aligned in the 256-bit container; column 0 sits at the top of bit nb*32-1.
    function automatic logic [32*MaxNb-1:0] shift_rows_perm(input logic [32*MaxNb-1:0] blk,
                                                            input int nb, input logic inv);
        logic [32*MaxNb-1:0] res;
        col_word_t           col;
        int                  bw;
        int                  off;
        int                  src;
        res = '0;
        bw  = 32 * nb;
        for (int c = 0; c < MaxNb; c++) begin
            if (c < nb) begin
                col = '0;
                for (int r = 0; r < 4; r++) begin
                    off = row_offset(nb, r);
                    src = inv ? (c - off + nb) % nb : (c + off) % nb;
                    col[31-8*r -: 8] = blk[bw-1-32*src-8*r -: 8];
                end
                res[bw-1-32*c -: 32] = col;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/shift_rows_pipe_if.sv
// Handshake/data bundle for shift_rows_pipe; slave is the DUT side, master the driver side.
interface shift_rows_pipe_if #(
    parameter int NB = 4
) ();
    localparam int BW = 32 * NB;

    logic          i_valid;
    logic          o_ready;
    logic          i_inv;
    logic [BW-1:0] i_block;
    logic          o_valid;
    logic          i_ready;
    logic [BW-1:0] o_block;
    logic          o_inv;

    modport slave (
        input  i_valid, i_inv, i_block, i_ready,
        output o_ready, o_valid, o_block, o_inv
    );

    modport master (
        output i_valid, i_inv, i_block, i_ready,
        input  o_ready, o_valid, o_block, o_inv
    );
endinterface

// File: rtl/skid_buffer.sv
// Generic 2-entry valid/ready buffer: OUT register plus SKID register, ready is purely registered.
module skid_buffer
    import aes_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_data
);
    skid_state_e  r_state;
    skid_state_e  w_state_next;
    logic [W-1:0] r_out;
    logic [W-1:0] r_skid;
    logic         w_in_xfer;
    logic         w_out_xfer;
    logic         w_load_out;
    logic         w_load_skid;
    logic         w_pop_skid;

    // Flags decode straight from the state register, so ready never depends on i_ready.
    assign o_ready    = (r_state != StFull);
    assign o_valid    = (r_state != StEmpty);
    assign o_data     = r_out;
    assign w_in_xfer  = i_valid & o_ready;
    assign w_out_xfer = o_valid & i_ready;

    always_comb begin
        w_state_next = r_state;
        w_load_out   = 1'b0;
        w_load_skid  = 1'b0;
        w_pop_skid   = 1'b0;
        unique case (r_state)
            StEmpty: begin
                if (w_in_xfer) begin
                    w_load_out   = 1'b1;
                    w_state_next = StOne;
                end
            end
            StOne: begin
                if (w_in_xfer && w_out_xfer) begin
                    w_load_out = 1'b1;
                end else if (w_out_xfer) begin
                    w_state_next = StEmpty;
                end else if (w_in_xfer) begin
                    w_load_skid  = 1'b1;
                    w_state_next = StFull;
                end
            end
            StFull: begin
                if (i_ready) begin
                    w_pop_skid   = 1'b1;
                    w_state_next = StOne;
                end
            end
            default: w_state_next = StEmpty;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StEmpty;
            r_out   <= '0;
            r_skid  <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_load_out) begin
                r_out <= i_data;
            end else if (w_pop_skid) begin
                r_out <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= i_data;
            end
        end
    end

endmodule

// File: rtl/shift_rows_pipe.sv
// Registered ShiftRows/InvShiftRows for Rijndael NB=4/6/8 behind a skid buffer.
// Optional accepted-block counter enabled by defining SHIFT_ROWS_STATS_EN.
module shift_rows_pipe
    import aes_pkg::*;
#(
    parameter int NB = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    shift_rows_pipe_if.slave        bus
`ifdef SHIFT_ROWS_STATS_EN
    ,
    output logic [31:0]             o_blk_count
`endif
);
    localparam int BW = 32 * NB;

    if (!nb_legal(NB)) begin : g_bad_nb
        $error("shift_rows_pipe: NB must be 4, 6 or 8");
    end

    logic [32*MaxNb-1:0] w_blk_ext;
    logic [BW-1:0]       w_perm;
    logic [BW:0]         w_out_data;

    always_comb begin
        w_blk_ext           = '0;
        w_blk_ext[BW-1:0]   = bus.i_block;
    end

    assign w_perm = BW'(shift_rows_perm(w_blk_ext, NB, bus.i_inv));

    skid_buffer #(
        .W (BW + 1)
    ) u_skid (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (bus.i_valid),
        .o_ready (bus.o_ready),
        .i_data  ({w_perm, bus.i_inv}),
        .o_valid (bus.o_valid),
        .i_ready (bus.i_ready),
        .o_data  (w_out_data)
    );

    assign bus.o_block = w_out_data[BW:1];
    assign bus.o_inv   = w_out_data[0];

`ifdef SHIFT_ROWS_STATS_EN
    logic [31:0] r_blk_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_blk_count <= '0;
        end else if (bus.i_valid && bus.o_ready) begin
            r_blk_count <= r_blk_count + 32'd1;
        end
    end

    assign o_blk_count = r_blk_count;
`endif

endmodule
